// File: rtl/conv_pkg.sv
// Shared definitions for the convolution tile controller: FSM state encoding,
// default tile geometry and the mapping of copy-sequencer slots to phases.
package conv_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int W_LEN_DEF  = 16;
    localparam int I_LEN_DEF  = 28;
    localparam int O_LEN_DEF  = 16;
    localparam int CNT_W_DEF  = 8;

    // Copy sequencer slots: weight load, input load, output drain
    localparam int N_COPY = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_I,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

    // Phase in which copy slot idx is active
    function automatic state_t copy_phase(input int idx);
        return (idx == 0) ? LOAD_W : (idx == 1) ? LOAD_I : DRAIN;
    endfunction

endpackage

// File: rtl/ram_copy_seq.sv
// RAM-to-RAM copy sequencer: a read index that advances while enabled and a
// write strobe/index that trail it by one cycle to cover the registered read.
module ram_copy_seq #(
    parameter int LEN   = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clear,
    input  logic             run,
    output logic [CNT_W-1:0] rd_idx,
    output logic             wr_en,
    output logic [CNT_W-1:0] wr_idx,
    output logic             last_wr
);

    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] wr_idx_reg;
    logic             wr_en_reg;
    logic             issue;

    assign issue = run && (cnt_reg < LEN_C);

    // Read counter plus one-cycle-delayed write strobe and index
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            cnt_reg    <= '0;
            wr_idx_reg <= '0;
            wr_en_reg  <= 1'b0;
        end else begin
            wr_en_reg <= issue;
            if (issue) begin
                cnt_reg    <= cnt_reg + 1'b1;
                wr_idx_reg <= cnt_reg;
            end
        end
    end

    assign rd_idx  = cnt_reg;
    assign wr_en   = wr_en_reg;
    assign wr_idx  = wr_idx_reg;
    assign last_wr = wr_en_reg && (wr_idx_reg == LAST_C);

endmodule

// File: rtl/conv_tile_controller.sv
// Convolution tile sequencer: loads weights and inputs on-chip, streams them
// to the PE group, collects results and drains them off-chip.
// Optional feature macro: CONV_TILE_CTRL_PERF_EN adds perf_cycles/perf_stalls.
module conv_tile_controller
    import conv_pkg::*;
#(
    parameter int AddressWidth = ADDR_W_DEF,
    parameter int W_Len        = W_LEN_DEF,
    parameter int I_Len        = I_LEN_DEF,
    parameter int O_Len        = O_LEN_DEF,
    parameter int CntWidth     = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    aclr,
    input  logic                    start,
    input  logic                    first_tile,
    input  logic [AddressWidth-1:0] W_Off_Base,
    input  logic [AddressWidth-1:0] I_Off_Base,
    input  logic [AddressWidth-1:0] O_Off_Base,
    input  logic                    W_DataInRdy,
    input  logic                    I_DataInRdy,
    input  logic                    O_DataOutValid,
    output logic [AddressWidth-1:0] W_Off_RAddr,
    output logic [AddressWidth-1:0] I_Off_RAddr,
    output logic [AddressWidth-1:0] O_Off_WAddr,
    output logic [AddressWidth-1:0] O_Off_RAddr,
    output logic [AddressWidth-1:0] W_On_WAddr,
    output logic [AddressWidth-1:0] W_On_RAddr,
    output logic [AddressWidth-1:0] I_On_WAddr,
    output logic [AddressWidth-1:0] I_On_RAddr,
    output logic [AddressWidth-1:0] O_On_WAddr,
    output logic [AddressWidth-1:0] O_On_RAddr,
    output logic                    W_On_WEn,
    output logic                    I_On_WEn,
    output logic                    O_On_WEn,
    output logic                    O_Off_WEn,
    output logic                    W_Off_WEn,
    output logic                    I_Off_WEn,
    output logic                    W_DataInValid,
    output logic                    I_DataInValid,
    output logic                    O_On_Fill,
    output logic                    busy,
    output logic                    done
`ifdef CONV_TILE_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_cycles,
    output logic [31:0]             perf_stalls
`endif
);

    localparam logic [CntWidth-1:0] W_LEN_C  = CntWidth'(W_Len);
    localparam logic [CntWidth-1:0] I_LEN_C  = CntWidth'(I_Len);
    localparam logic [CntWidth-1:0] O_LEN_C  = CntWidth'(O_Len);
    localparam logic [CntWidth-1:0] O_LAST_C = CntWidth'(O_Len - 1);

    state_t                  state_reg;
    logic [AddressWidth-1:0] w_base_reg, i_base_reg, o_base_reg;
    logic                    first_reg;
    logic [CntWidth-1:0]     w_cnt_reg, i_cnt_reg, k_reg;
    logic                    w_valid_reg, i_valid_reg;

    logic                    copy_clear;
    logic [N_COPY-1:0]       copy_run, copy_wr_en, copy_last;
    logic [CntWidth-1:0]     copy_rd_idx [N_COPY];
    logic [CntWidth-1:0]     copy_wr_idx [N_COPY];

    logic                    w_issue, i_issue, o_accept;

    assign copy_clear = (state_reg == IDLE) && start;
    assign w_issue    = (state_reg == COMPUTE) && W_DataInRdy && (w_cnt_reg < W_LEN_C);
    assign i_issue    = (state_reg == COMPUTE) && I_DataInRdy && (i_cnt_reg < I_LEN_C);
    assign o_accept   = (state_reg == COMPUTE) && O_DataOutValid && (k_reg < O_LEN_C);

    genvar gi;
    generate
        for (gi = 0; gi < N_COPY; gi++) begin : g_copy
            localparam int SEQ_LEN = (gi == 0) ? W_Len : (gi == 1) ? I_Len : O_Len;
            assign copy_run[gi] = (state_reg == copy_phase(gi));
            ram_copy_seq #(
                .LEN   (SEQ_LEN),
                .CNT_W (CntWidth)
            ) u_seq (
                .clk     (clk),
                .srst    (aclr),
                .clear   (copy_clear),
                .run     (copy_run[gi]),
                .rd_idx  (copy_rd_idx[gi]),
                .wr_en   (copy_wr_en[gi]),
                .wr_idx  (copy_wr_idx[gi]),
                .last_wr (copy_last[gi])
            );
        end
    endgenerate

    // Tile FSM with compute-phase stream counters and PE input valids
    always_ff @(posedge clk) begin
        if (aclr) begin
            state_reg   <= IDLE;
            w_base_reg  <= '0;
            i_base_reg  <= '0;
            o_base_reg  <= '0;
            first_reg   <= 1'b0;
            w_cnt_reg   <= '0;
            i_cnt_reg   <= '0;
            k_reg       <= '0;
            w_valid_reg <= 1'b0;
            i_valid_reg <= 1'b0;
        end else begin
            w_valid_reg <= w_issue;
            i_valid_reg <= i_issue;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        w_base_reg <= W_Off_Base;
                        i_base_reg <= I_Off_Base;
                        o_base_reg <= O_Off_Base;
                        first_reg  <= first_tile;
                        w_cnt_reg  <= '0;
                        i_cnt_reg  <= '0;
                        k_reg      <= '0;
                        state_reg  <= LOAD_W;
                    end
                end
                LOAD_W:  if (copy_last[0]) state_reg <= LOAD_I;
                LOAD_I:  if (copy_last[1]) state_reg <= COMPUTE;
                COMPUTE: begin
                    if (w_issue) w_cnt_reg <= w_cnt_reg + 1'b1;
                    if (i_issue) i_cnt_reg <= i_cnt_reg + 1'b1;
                    if (o_accept) begin
                        k_reg <= k_reg + 1'b1;
                        if (k_reg == O_LAST_C) state_reg <= DRAIN;
                    end
                end
                DRAIN:   if (copy_last[2]) state_reg <= DONE;
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign W_Off_RAddr   = w_base_reg + AddressWidth'(copy_rd_idx[0]);
    assign W_On_WEn      = copy_wr_en[0];
    assign W_On_WAddr    = AddressWidth'(copy_wr_idx[0]);
    assign I_Off_RAddr   = i_base_reg + AddressWidth'(copy_rd_idx[1]);
    assign I_On_WEn      = copy_wr_en[1];
    assign I_On_WAddr    = AddressWidth'(copy_wr_idx[1]);
    assign O_Off_WEn     = copy_wr_en[2];
    assign O_Off_WAddr   = o_base_reg + AddressWidth'(copy_wr_idx[2]);
    assign O_On_RAddr    = (state_reg == DRAIN) ? AddressWidth'(copy_rd_idx[2])
                                                : AddressWidth'(k_reg);
    assign W_On_RAddr    = AddressWidth'(w_cnt_reg);
    assign I_On_RAddr    = AddressWidth'(i_cnt_reg);
    assign O_On_WAddr    = AddressWidth'(k_reg);
    assign O_On_WEn      = o_accept;
    assign O_On_Fill     = (state_reg == COMPUTE) && !first_reg;
    assign W_DataInValid = w_valid_reg;
    assign I_DataInValid = i_valid_reg;
    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == DONE);
    assign O_Off_RAddr   = '0;
    assign W_Off_WEn     = 1'b0;
    assign I_Off_WEn     = 1'b0;

`ifdef CONV_TILE_CTRL_PERF_EN
    logic [31:0] perf_cycles_reg, perf_stalls_reg;
    logic        stall;

    assign stall = (state_reg == COMPUTE) &&
                   ((!W_DataInRdy && (w_cnt_reg < W_LEN_C)) ||
                    (!I_DataInRdy && (i_cnt_reg < I_LEN_C)));

    // Busy-cycle and compute-stall counters for the most recent tile
    always_ff @(posedge clk) begin
        if (aclr || copy_clear) begin
            perf_cycles_reg <= '0;
            perf_stalls_reg <= '0;
        end else begin
            if (busy)  perf_cycles_reg <= perf_cycles_reg + 1'b1;
            if (stall) perf_stalls_reg <= perf_stalls_reg + 1'b1;
        end
    end

    assign perf_cycles = perf_cycles_reg;
    assign perf_stalls = perf_stalls_reg;
`endif

endmodule

// File: tb/tb_conv_tile_controller.sv
// Scoreboard bench for conv_tile_controller: expected RAM write addresses are
// queued when a tile is started and popped as the DUT issues each write.
module tb_conv_tile_controller;

    logic        clk = 1'b0;
    logic        aclr, start, first_tile;
    logic [31:0] W_Off_Base, I_Off_Base, O_Off_Base;
    logic        W_DataInRdy, I_DataInRdy, O_DataOutValid;
    logic [31:0] W_Off_RAddr, I_Off_RAddr, O_Off_WAddr, O_Off_RAddr;
    logic [31:0] W_On_WAddr, W_On_RAddr, I_On_WAddr, I_On_RAddr, O_On_WAddr, O_On_RAddr;
    logic        W_On_WEn, I_On_WEn, O_On_WEn, O_Off_WEn, W_Off_WEn, I_Off_WEn;
    logic        W_DataInValid, I_DataInValid, O_On_Fill, busy, done;
`ifdef CONV_TILE_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_stalls;
`endif

    conv_tile_controller dut (
        .clk(clk), .aclr(aclr), .start(start), .first_tile(first_tile),
        .W_Off_Base(W_Off_Base), .I_Off_Base(I_Off_Base), .O_Off_Base(O_Off_Base),
        .W_DataInRdy(W_DataInRdy), .I_DataInRdy(I_DataInRdy), .O_DataOutValid(O_DataOutValid),
        .W_Off_RAddr(W_Off_RAddr), .I_Off_RAddr(I_Off_RAddr), .O_Off_WAddr(O_Off_WAddr),
        .O_Off_RAddr(O_Off_RAddr), .W_On_WAddr(W_On_WAddr), .W_On_RAddr(W_On_RAddr),
        .I_On_WAddr(I_On_WAddr), .I_On_RAddr(I_On_RAddr), .O_On_WAddr(O_On_WAddr),
        .O_On_RAddr(O_On_RAddr), .W_On_WEn(W_On_WEn), .I_On_WEn(I_On_WEn),
        .O_On_WEn(O_On_WEn), .O_Off_WEn(O_Off_WEn), .W_Off_WEn(W_Off_WEn),
        .I_Off_WEn(I_Off_WEn), .W_DataInValid(W_DataInValid), .I_DataInValid(I_DataInValid),
        .O_On_Fill(O_On_Fill), .busy(busy), .done(done)
`ifdef CONV_TILE_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] q_w_on[$], q_w_off[$], q_i_on[$], q_i_off[$];
    logic [31:0] q_o_on[$], q_o_off[$], q_o_onr[$];
    logic [31:0] prev_w_off, prev_i_off, prev_o_onr;
    bit          exp_fill, compute, w_prev, i_prev;
    int          w_iss, i_iss, comp_cyc, drain_words, done_cnt, done_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // Samples outputs once per cycle and retires scoreboard entries
    task automatic monitor();
        logic [31:0] e;
        if (compute) begin
            check("w_on_raddr", W_On_RAddr, w_iss);
            check("w_valid", {31'b0, W_DataInValid}, {31'b0, w_prev});
            check("i_on_raddr", I_On_RAddr, i_iss);
            check("i_valid", {31'b0, I_DataInValid}, {31'b0, i_prev});
            w_prev = W_DataInRdy && (w_iss < 16);
            i_prev = I_DataInRdy && (i_iss < 28);
            if (w_prev) w_iss++;
            if (i_prev) i_iss++;
            comp_cyc++;
        end
        if (W_On_WEn) begin
            if (q_w_on.size() == 0) check("w_on_extra", 32'd1, 32'd0);
            else begin
                e = q_w_on.pop_front();  check("w_on_waddr", W_On_WAddr, e);
                e = q_w_off.pop_front(); check("w_off_raddr", prev_w_off, e);
            end
        end
        if (I_On_WEn) begin
            if (q_i_on.size() == 0) check("i_on_extra", 32'd1, 32'd0);
            else begin
                e = q_i_on.pop_front();  check("i_on_waddr", I_On_WAddr, e);
                e = q_i_off.pop_front(); check("i_off_raddr", prev_i_off, e);
                if (I_On_WAddr == 32'd27) begin
                    compute = 1; w_iss = 0; i_iss = 0; w_prev = 0; i_prev = 0; comp_cyc = 0;
                end
            end
        end
        if (O_On_WEn) begin
            if (q_o_on.size() == 0) check("o_on_extra", 32'd1, 32'd0);
            else begin
                e = q_o_on.pop_front(); check("o_on_waddr", O_On_WAddr, e);
                check("o_on_fill", {31'b0, O_On_Fill}, {31'b0, exp_fill});
                if (O_On_WAddr == 32'd15) compute = 0;
            end
        end
        if (O_Off_WEn) begin
            if (q_o_off.size() == 0) check("o_off_extra", 32'd1, 32'd0);
            else begin
                e = q_o_off.pop_front(); check("o_off_waddr", O_Off_WAddr, e);
                e = q_o_onr.pop_front(); check("o_on_raddr", prev_o_onr, e);
                drain_words++;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_w_off = W_Off_RAddr;
        prev_i_off = I_Off_RAddr;
        prev_o_onr = O_On_RAddr;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        q_w_on.delete(); q_w_off.delete(); q_i_on.delete(); q_i_off.delete();
        q_o_on.delete(); q_o_off.delete(); q_o_onr.delete();
        compute = 0; drain_words = 0; done_cnt = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_wen"}, {28'b0, W_On_WEn, I_On_WEn, O_On_WEn, O_Off_WEn}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_valid_fill"}, {29'b0, W_DataInValid, I_DataInValid, O_On_Fill}, 32'd0);
    endtask

    // Starts one tile, queues its expected writes, then drives it to completion
    task automatic run_tile(input logic [31:0] wb, input logic [31:0] ib, input logic [31:0] ob,
                            input bit ft, input bit stall, input bit restart, input bit abort,
                            input string name);
        int start_cyc;
        flush();
        for (int n = 0; n < 16; n++) begin
            q_w_on.push_back(n); q_w_off.push_back(wb + n);
            q_o_on.push_back(n); q_o_off.push_back(ob + n); q_o_onr.push_back(n);
        end
        for (int n = 0; n < 28; n++) begin
            q_i_on.push_back(n); q_i_off.push_back(ib + n);
        end
        exp_fill = !ft;
        W_Off_Base = wb; I_Off_Base = ib; O_Off_Base = ob; first_tile = ft;
        W_DataInRdy = 1; I_DataInRdy = 1; O_DataOutValid = 1;
        start = 1;
        tick();
        start_cyc = cyc;
        start = 0;
        W_Off_Base = '0; I_Off_Base = '0; O_Off_Base = '0; first_tile = ~ft;
        check({name, "_busy_on"}, {31'b0, busy}, 32'd1);
        for (int n = 0; n < 300 && done_cnt == 0; n++) begin
            W_DataInRdy = !(stall && compute && comp_cyc >= 5 && comp_cyc <= 7);
            start = restart && (n == 20);
            if (abort && drain_words == 5) begin
                aclr = 1;
                tick();
                aclr = 0;
                check_idle({name, "_abort"});
                $display("tile %s aborted after %0d drain words", name, drain_words);
                flush();
                return;
            end
            tick();
        end
        start = 0;
        check({name, "_timeout"}, {31'b0, done_cnt != 0}, 32'd1);
        check({name, "_latency"}, done_cyc - start_cyc, 32'd80);
`ifdef CONV_TILE_CTRL_PERF_EN
        check({name, "_perf_cycles"}, perf_cycles, 32'd80);
        check({name, "_perf_stalls"}, perf_stalls, stall ? 32'd3 : 32'd0);
`endif
        for (int n = 0; n < 10; n++) tick();
        check({name, "_done_once"}, done_cnt, 32'd1);
        check({name, "_busy_off"}, {31'b0, busy}, 32'd0);
        check({name, "_q_left"}, q_w_on.size() + q_i_on.size() + q_o_on.size() + q_o_off.size(), 32'd0);
        $display("tile %s done latency=%0d drain_words=%0d", name, done_cyc - start_cyc, drain_words);
    endtask

    initial begin
        aclr = 1; start = 0; first_tile = 0;
        W_Off_Base = '0; I_Off_Base = '0; O_Off_Base = '0;
        W_DataInRdy = 0; I_DataInRdy = 0; O_DataOutValid = 0;
        flush();
        repeat (3) tick();
        aclr = 0;
        check_idle("reset");
        check("reset_addr_or", W_Off_RAddr | I_Off_RAddr | O_Off_WAddr | W_On_WAddr | W_On_RAddr |
              I_On_WAddr | I_On_RAddr | O_On_WAddr | O_On_RAddr, 32'd0);
        check("tie_offs", O_Off_RAddr | {30'b0, W_Off_WEn, I_Off_WEn}, 32'd0);

        run_tile(32'h100, 32'h200, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, "basic");
        run_tile(32'h1000, 32'h2000, 32'h3000, 1'b1, 1'b1, 1'b0, 1'b0, "stall");
        run_tile(32'h40, 32'h80, 32'hC0, 1'b0, 1'b0, 1'b1, 1'b0, "restart");
        run_tile(32'h500, 32'h600, 32'h700, 1'b0, 1'b0, 1'b0, 1'b1, "abort");
        check("abort_raddr", W_On_RAddr | O_On_WAddr | W_Off_RAddr, 32'd0);
        run_tile(32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, "wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
